// File: rtl/dmem_pkg.sv
// Shared size codes, FSM states and alignment helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic size_undef(input logic [2:0] control);
        return !(control inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
    endfunction

    // Undefined codes behave as word accesses, so they need full alignment too.
    function automatic logic misaligned(input logic [2:0] control, input logic [1:0] addr_lo);
        logic m;
        case (control)
            SZ_B, SZ_BU: m = 1'b0;
            SZ_H, SZ_HU: m = addr_lo[0];
            default:     m = (addr_lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: store strobes/replicated data and load lane extraction with extension.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]        control,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] r_word,
    output logic [3:0]        strb_c,
    output logic [DATA_W-1:0] w_word_c,
    output logic [DATA_W-1:0] r_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = r_word[7:0];
        case (addr_lo)
            2'd0: byte_sel = r_word[7:0];
            2'd1: byte_sel = r_word[15:8];
            2'd2: byte_sel = r_word[23:16];
            2'd3: byte_sel = r_word[31:24];
            default: byte_sel = r_word[7:0];
        endcase
        // Halfwords ignore addr_lo[0]; the top decides whether that is a fault.
        half_sel = addr_lo[1] ? r_word[31:16] : r_word[15:0];
    end

    always_comb begin
        strb_c   = 4'b1111;
        w_word_c = w_data;
        r_data_c = r_word;
        case (control)
            SZ_B, SZ_BU: begin
                strb_c   = 4'b0001 << addr_lo;
                w_word_c = {4{w_data[7:0]}};
                r_data_c = (control == SZ_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h000000, byte_sel};
            end
            SZ_H, SZ_HU: begin
                strb_c   = addr_lo[1] ? 4'b1100 : 4'b0011;
                w_word_c = {2{w_data[15:0]}};
                r_data_c = (control == SZ_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
            end
            default: begin
                strb_c   = 4'b1111;
                w_word_c = w_data;
                r_data_c = r_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed wait states and held response.
// Optional fault reporting enabled by defining DMEM_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_W_En,
    input  logic [2:0]        Req_Control,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [DATA_W-1:0] Req_W_Data,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] Rsp_R_Data,
    output logic              Rsp_Err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t       state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              accept, access;

    logic              req_we;
    logic [2:0]        req_ctrl;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    logic              in_range, fault, blocked, do_store;
    logic [DATA_W-1:0] r_word, lane_rdata, w_word, rsp_data_d;
    logic [3:0]        strb;

    assign accept   = (state == IDLE) && Req_Ready && Req_Valid;
    assign idx      = req_addr[IDX_W+1:2];
    assign in_range = {2'b00, req_addr[ADDR_W-1:2]} < 32'(DEPTH_WORDS);
    assign r_word   = in_range ? mem[idx] : '0;

`ifdef DMEM_ERR_EN
    assign fault = misaligned(req_ctrl, req_addr[1:0]) || size_undef(req_ctrl) || !in_range;
`else
    assign fault = 1'b0;
`endif

    assign blocked    = fault || !in_range;
    assign do_store   = access && req_we && !blocked;
    assign rsp_data_d = (req_we || blocked) ? '0 : lane_rdata;

    dmem_lane_unit u_lane (
        .control  (req_ctrl),
        .addr_lo  (req_addr[1:0]),
        .w_data   (req_wdata),
        .r_word   (r_word),
        .strb_c   (strb),
        .w_word_c (w_word),
        .r_data_c (lane_rdata)
    );

    // Next-state: the access edge is the one where the wait counter is already zero.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (Rsp_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            Req_Ready  <= 1'b0;
            Rsp_Valid  <= 1'b0;
            Rsp_R_Data <= '0;
            Rsp_Err    <= 1'b0;
            req_we     <= 1'b0;
            req_ctrl   <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            Req_Ready <= (state_d == IDLE);
            Rsp_Valid <= (state_d == RESP);
            if (accept) begin
                req_we    <= Req_W_En;
                req_ctrl  <= Req_Control;
                req_addr  <= Req_Addr;
                req_wdata <= Req_W_Data;
            end
            if (access) begin
                Rsp_R_Data <= rsp_data_d;
                Rsp_Err    <= fault;
            end else if (state == RESP && Rsp_Ready) begin
                Rsp_R_Data <= '0;
                Rsp_Err    <= 1'b0;
            end
        end
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge CLK) begin
        if (!RST && do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= w_word[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;

    logic        CLK;
    logic        RST;
    logic        req_valid, req_valid_0, req_w_en, rsp_ready, rsp_ready_0;
    logic [2:0]  req_control;
    logic [31:0] req_addr, req_w_data;
    logic        req_ready, rsp_valid, rsp_err;
    logic        req_ready_0, rsp_valid_0, rsp_err_0;
    logic [31:0] rsp_rdata, rsp_rdata_0;

    logic [7:0]  mdl [DEPTH*4];
    int          n_tests = 0;
    int          n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .CLK(CLK), .RST(RST), .Req_Valid(req_valid), .Req_Ready(req_ready),
        .Req_W_En(req_w_en), .Req_Control(req_control), .Req_Addr(req_addr),
        .Req_W_Data(req_w_data), .Rsp_Valid(rsp_valid), .Rsp_Ready(rsp_ready),
        .Rsp_R_Data(rsp_rdata), .Rsp_Err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .Req_Valid(req_valid_0), .Req_Ready(req_ready_0),
        .Req_W_En(req_w_en), .Req_Control(req_control), .Req_Addr(req_addr),
        .Req_W_Data(req_w_data), .Rsp_Valid(rsp_valid_0), .Rsp_Ready(rsp_ready_0),
        .Rsp_R_Data(rsp_rdata_0), .Rsp_Err(rsp_err_0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour expressed as byte-granular memory operations.
    function automatic void model(input logic we, input logic [2:0] c, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int unsigned size;
        bit          sgn;
        bit          in_rng;
        longint unsigned au, base;
        size = 4; sgn = 0;
        case (c)
            3'b000: begin size = 1; sgn = 1; end
            3'b001: begin size = 2; sgn = 1; end
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 4;
        endcase
        rd = '0; er = 1'b0;
        au = longint'(a);
        in_rng = (au / 4) < DEPTH;
`ifdef DMEM_ERR_EN
        if (!(c inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (au % size) != 0 || !in_rng) begin
            er = 1'b1;
            return;
        end
        base = au;
`else
        if (!in_rng) return;
        base = au - (au % size);
`endif
        if (we) begin
            for (int i = 0; i < int'(size); i++) mdl[int'(base) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < int'(size); i++) rd[8*i +: 8] = mdl[int'(base) + i];
            if (sgn && size == 1) rd = {{24{rd[7]}}, rd[7:0]};
            if (sgn && size == 2) rd = {{16{rd[15]}}, rd[15:0]};
        end
    endfunction

    // One full handshake on either instance; sel=1 targets the zero-wait instance.
    task automatic xact(input bit sel, input logic we, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int k;
        @(negedge CLK);
        req_w_en = we; req_control = c; req_addr = a; req_w_data = wd;
        if (sel) req_valid_0 = 1'b1; else req_valid = 1'b1;
        k = 0;
        while (!(sel ? req_ready_0 : req_ready) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("req_ready_wait", 32'(sel ? req_ready_0 : req_ready), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0; req_valid_0 = 1'b0;
        k = 0;
        while (!(sel ? rsp_valid_0 : rsp_valid) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        lat = k;
        rd  = sel ? rsp_rdata_0 : rsp_rdata;
        er  = sel ? rsp_err_0 : rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(sel ? rsp_valid_0 : rsp_valid), 32'd1);
            chk("hold_data", sel ? rsp_rdata_0 : rsp_rdata, rd);
            chk("hold_req_ready", 32'(sel ? req_ready_0 : req_ready), 32'd0);
        end
        if (sel) rsp_ready_0 = 1'b1; else rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0; rsp_ready_0 = 1'b0;
        chk("ready_after_rsp", 32'(sel ? req_ready_0 : req_ready), 32'd1);
        chk("valid_after_rsp", 32'(sel ? rsp_valid_0 : rsp_valid), 32'd0);
    endtask

    task automatic op(input logic we, input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, output logic [31:0] rd);
        logic [31:0] erd, grd;
        logic        eer, ger;
        int          lat;
        model(we, c, a, wd, erd, eer);
        xact(1'b0, we, c, a, wd, hold, grd, ger, lat);
        chk("latency", 32'(lat), 32'(WS + 1));
        chk(we ? "store_rdata" : "load_rdata", grd, erd);
        chk("rsp_err", 32'(ger), 32'(eer));
        rd = grd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, pre;
        logic        e;
        int          lat, k;

        RST = 1'b1;
        req_valid = 0; req_valid_0 = 0; req_w_en = 0; rsp_ready = 0; rsp_ready_0 = 0;
        req_control = 3'b000; req_addr = '0; req_w_data = '0;
        repeat (3) @(negedge CLK);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        RST = 1'b0;

        for (int w = 0; w < 64; w++) op(1'b1, SZ_W, 32'(w * 4), $urandom, 0, d);

        op(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 0, d);
        op(1'b0, SZ_W, 32'h10, 32'h0, 0, d);
        chk("t1_lw", d, 32'hDEADBEEF);

        op(1'b1, SZ_W, 32'h10, 32'h0, 0, d);
        op(1'b1, SZ_B, 32'h11, 32'h80, 0, d);
        op(1'b0, SZ_B, 32'h11, 32'h0, 0, d);
        chk("t2_lb", d, 32'hFFFFFF80);
        op(1'b0, SZ_BU, 32'h11, 32'h0, 0, d);
        chk("t2_lbu", d, 32'h00000080);
        op(1'b0, SZ_W, 32'h10, 32'h0, 0, d);
        chk("t2_lw", d, 32'h00008000);

        op(1'b1, SZ_H, 32'h12, 32'hBEEF, 0, d);
        op(1'b0, SZ_H, 32'h12, 32'h0, 0, d);
        chk("t3_lh", d, 32'hFFFFBEEF);
        op(1'b0, SZ_HU, 32'h12, 32'h0, 0, d);
        chk("t3_lhu", d, 32'h0000BEEF);
        op(1'b0, SZ_W, 32'h10, 32'h0, 0, d);
        chk("t3_lw", d, 32'hBEEF8000);

        op(1'b0, SZ_W, 32'h10, 32'h0, 5, d);

        op(1'b0, SZ_W, 32'h13, 32'h0, 0, d);
`ifdef DMEM_ERR_EN
        chk("t5_lw13", d, 32'h0);
`else
        chk("t5_lw13", d, 32'hBEEF8000);
`endif
        op(1'b1, SZ_W, 32'h13, 32'hAAAA5555, 0, d);
        op(1'b0, SZ_W, 32'h10, 32'h0, 0, d);
`ifdef DMEM_ERR_EN
        chk("t5_sw13", d, 32'hBEEF8000);
`else
        chk("t5_sw13", d, 32'hAAAA5555);
`endif
        op(1'b0, SZ_W, 32'(DEPTH * 4), 32'h0, 0, d);

        // Reset lands while the store is still waiting; it must never commit.
        pre = {mdl[35], mdl[34], mdl[33], mdl[32]};
        @(negedge CLK);
        req_w_en = 1'b1; req_control = SZ_W; req_addr = 32'h20; req_w_data = 32'h12345678;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("t6_accept", 32'(req_ready), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
            chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        RST = 1'b0;
        op(1'b0, SZ_W, 32'h20, 32'h0, 0, d);
        chk("t6_lw_prior", d, pre);

        xact(1'b1, 1'b1, SZ_W, 32'h40, 32'h0BADF00D, 0, d, e, lat);
        chk("ws0_store_latency", 32'(lat), 32'd1);
        xact(1'b1, 1'b0, SZ_W, 32'h40, 32'h0, 1, d, e, lat);
        chk("ws0_load_latency", 32'(lat), 32'd1);
        chk("ws0_load_data", d, 32'h0BADF00D);
        chk("ws0_load_err", 32'(e), 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
            else a = 32'($urandom_range(0, 255));
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
               int'($urandom_range(0, 3)), d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
